// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: byte-serial adder/subtractor with a valid/ready request and
// result handshake.
//
// A request is accepted in IDLE, then one 8-bit add slice walks the operands
// least-significant byte first, one byte per clock, with the slice carry
// registered between bytes. After XLEN/8 CALC edges the result is held in
// DONE until the consumer takes it.
//
// Build option: define ADD_SEQ_CTRL_FLAGS_EN to generate the N/Z/C/V flags.
// Without it the flag ports remain but are tied to 0. out_sum and the
// latency are the same in both builds.
module add_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            in_sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_sum,
    output logic            out_n,
    output logic            out_z,
    output logic            out_c,
    output logic            out_v,
    output logic            busy
);

    // Number of byte slices, and the width of the byte index that walks them.
    localparam int NB = XLEN / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    // Latched request and the result under construction.
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic            r_sub;
    logic [XLEN-1:0] r_sum;
    logic [IW-1:0]   r_idx;
    logic            r_carry;

    // Handshake / control decode.
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_busy;
    logic            w_accept;
    logic            w_step;
    logic            w_last;

    // Byte views of the latched operands and the per-byte write enables.
    logic [7:0]      w_a_bytes [NB];
    logic [7:0]      w_b_bytes [NB];
    logic [NB-1:0]   w_byte_we;

    // The single 8-bit slice.
    logic [7:0]      w_op_a;
    logic [7:0]      w_op_b;
    logic            w_cin;
    logic [8:0]      w_slice;
    logic [7:0]      w_slice_sum;
    logic            w_cout;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-derived handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // in_ready is also held low while reset is asserted, so a request can
    // never appear to be accepted during reset.
    assign in_ready  = w_in_ready & rst_n;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;

    assign w_last = (r_idx == LAST_IDX);

    // Split the latched operands into bytes and decode which result byte
    // the current CALC edge writes.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
            assign w_a_bytes[gi] = r_a[8*gi +: 8];
            assign w_b_bytes[gi] = r_b[8*gi +: 8];
            assign w_byte_we[gi] = w_step && (r_idx == IW'(gi));
        end
    endgenerate

    // Slice inputs: B is inverted for subtract, and the subtract "+1" enters
    // as the carry-in of byte 0; later bytes take the registered carry.
    assign w_op_a      = w_a_bytes[r_idx];
    assign w_op_b      = w_b_bytes[r_idx] ^ {8{r_sub}};
    assign w_cin       = (r_idx == '0) ? r_sub : r_carry;
    assign w_slice     = {1'b0, w_op_a} + {1'b0, w_op_b} + {8'd0, w_cin};
    assign w_slice_sum = w_slice[7:0];
    assign w_cout      = w_slice[8];

    // Operand latch: captured only on the accepting edge, later input
    // changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_sub <= in_sub;
        end
    end

    // Byte index and inter-byte carry: restart on accept, advance per CALC edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else if (w_step) begin
            r_idx   <= r_idx + 1'b1;
            r_carry <= w_cout;
        end
    end

    // Result register: cleared on accept, one byte filled per CALC edge,
    // otherwise held (so it stays stable throughout DONE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= '0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (w_byte_we[k]) begin
                    r_sum[8*k +: 8] <= w_slice_sum;
                end
            end
        end
    end

    assign out_sum = r_sum;

`ifdef ADD_SEQ_CTRL_FLAGS_EN
    // Carry into the MSB, carry out of the MSB and the zero flag are
    // captured on the edge that processes the last byte.
    logic r_cin_msb;
    logic r_cout_msb;
    logic r_zero;

    // Flag capture; cleared on accept so nothing stale survives a new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cin_msb  <= 1'b0;
            r_cout_msb <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            r_cin_msb  <= 1'b0;
            r_cout_msb <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_step && w_last) begin
            // Sum bit 7 = a7 ^ b7 ^ cin7, so cin7 falls out by XOR.
            r_cin_msb  <= w_op_a[7] ^ w_op_b[7] ^ w_slice_sum[7];
            r_cout_msb <= w_cout;
            r_zero     <= (w_slice_sum == 8'd0) && (r_sum[XLEN-9:0] == '0);
        end
    end

    assign out_n = r_sum[XLEN-1];
    assign out_z = r_zero;
    assign out_c = r_cout_msb;
    assign out_v = r_cin_msb ^ r_cout_msb;
`else
    assign out_n = 1'b0;
    assign out_z = 1'b0;
    assign out_c = 1'b0;
    assign out_v = 1'b0;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Testbench for add_seq_ctrl: the driver pushes the expected result of every
// accepted request into a scoreboard queue; an independent monitor pops and
// checks whenever the DUT raises out_valid, and checks the result is held
// stable while the consumer stalls.
module tb_add_seq_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            in_sub;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_sum;
    logic            out_n;
    logic            out_z;
    logic            out_c;
    logic            out_v;
    logic            busy;

    always #5 clk = ~clk;

    add_seq_ctrl #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_n     (out_n),
        .out_z     (out_z),
        .out_c     (out_c),
        .out_v     (out_v),
        .busy      (busy)
    );

    typedef struct {
        logic [XLEN-1:0] sum;
        logic [3:0]      nzcv;
        int              acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    bit   have  = 1'b0;   // monitor currently holds a presented result
    bit   rand_ready = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Reference: plain two's-complement arithmetic with overflow from the
    // operand/result sign rule.
    function automatic exp_t model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic sub);
        exp_t        e;
        logic [XLEN:0] full;
        logic        n, z, c, v;
        if (sub) full = {1'b0, a} - {1'b0, b} + {1'b1, {XLEN{1'b0}}};
        else     full = {1'b0, a} + {1'b0, b};
        e.sum = full[XLEN-1:0];
        n = e.sum[XLEN-1];
        z = (e.sum == 0);
        c = full[XLEN];
        if (sub) v = (a[XLEN-1] != b[XLEN-1]) && (e.sum[XLEN-1] != a[XLEN-1]);
        else     v = (a[XLEN-1] == b[XLEN-1]) && (e.sum[XLEN-1] != a[XLEN-1]);
`ifdef ADD_SEQ_CTRL_FLAGS_EN
        e.nzcv = {n, z, c, v};
`else
        e.nzcv = 4'b0000 & {n, z, c, v};
`endif
        e.acc = 0;
        return e;
    endfunction

    // Issue one request; returns after the accepting edge with the
    // expectation queued.
    task automatic send(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = s;
        while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=%0b want 1 within 200 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e     = model(a, b, s);
        e.acc = cycle;
        sb.push_back(e);
        $display("req  a=%08h b=%08h sub=%0b -> expect %08h nzcv=%04b", a, b, s, e.sum, e.nzcv);
        // Scramble the inputs: the latched request must be unaffected.
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_sub   = 1'($urandom);
    endtask

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Consumer back-pressure when enabled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: samples just after the falling edge.
    initial begin
        exp_t cur;
        cur.sum  = '0;
        cur.nzcv = '0;
        cur.acc  = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_out_valid: got out_valid=1 want 0 (no request pending, cycle %0d)", cycle);
                    end else begin
                        cur  = sb.pop_front();
                        have = 1'b1;
                        $display("resp sum=%08h nzcv=%04b latency=%0d", out_sum, {out_n, out_z, out_c, out_v}, cycle - cur.acc);
                        chk("latency", 64'(cycle - cur.acc), 64'd4);
                        chk("sum", 64'(out_sum), 64'(cur.sum));
                        chk("flags", 64'({out_n, out_z, out_c, out_v}), 64'(cur.nzcv));
                    end
                end else begin
                    chk("hold_sum", 64'(out_sum), 64'(cur.sum));
                    chk("hold_flags", 64'({out_n, out_z, out_c, out_v}), 64'(cur.nzcv));
                    chk("in_ready_in_done", 64'(in_ready), 64'd0);
                end
                if (out_ready) have = 1'b0;
            end
        end
    end

    // Main stimulus.
    initial begin
        int w;
        logic [XLEN-1:0] na, nb;
        logic            ns;

        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_sub   = 1'b0;

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_flags", 64'({out_n, out_z, out_c, out_v}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Directed corner cases.
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h0000_0000, 32'h0000_0001, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b1);

        // Consumer stall for 10 cycles with new requests presented.
        send(32'h1234_5678, 32'h1111_1111, 1'b0);
        out_ready = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("stall_reach_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = $urandom;
            in_b     = $urandom;
            in_sub   = 1'($urandom);
            #1;
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_busy", 64'(busy), 64'd1);
        end
        na = 32'hDEAD_BEEF;
        nb = 32'h0BAD_F00D;
        ns = 1'b1;
        @(negedge clk);
        in_a      = na;
        in_b      = nb;
        in_sub    = ns;
        out_ready = 1'b1;
        send(na, nb, ns);

        // Reset in the middle of an operation (byte index 2).
        send(32'hCAFE_0001, 32'h0102_0304, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("abort_out_sum", 64'(out_sum), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_flags", 64'({out_n, out_z, out_c, out_v}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready_after", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("abort_no_valid", 64'(out_valid), 64'd0);
        end

        // Randomized traffic with back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(pick(), pick(), 1'($urandom));
        end

        // Drain.
        w = 0;
        while ((sb.size() != 0 || have) && w < 500) begin
            @(negedge clk);
            w++;
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        if (w >= 500) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d results outstanding want 0", sb.size());
        end
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand width; it SHALL be a multiple of 8 and at least 16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; it SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, which marks a request as present.
REQ-005 The block SHALL have port in_ready, output, 1, which marks that a request can be accepted.
REQ-006 The block SHALL have ports in_a and in_b, input, XLEN each, which carry the operands.
REQ-007 The block SHALL have port in_sub, input, 1, which selects the operation: 0 computes a+b and 1 computes a-b.
REQ-008 The block SHALL have port out_valid, output, 1, which marks the result as valid.
REQ-009 The block SHALL have port out_ready, input, 1, which marks that the consumer accepts the result.
REQ-010 The block SHALL have port out_sum, output, XLEN, which carries the result.
REQ-011 The block SHALL have ports out_n, out_z, out_c and out_v, output, 1 each, which carry the negative, zero, carry and overflow flags.
REQ-012 The block SHALL have port busy, output, 1, which is high whenever the state is not IDLE.

Function
REQ-013 The block SHALL compute the result serially through one internal 8-bit add slice with carry-in, processing one byte per cycle, least-significant byte first.
REQ-014 The state machine SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 The transitions SHALL be:
- IDLE to CALC on in_valid && in_ready.
- CALC to DONE after the last byte is processed.
- DONE to IDLE on out_valid && out_ready.
REQ-016 in_ready SHALL equal (state==IDLE); a request SHALL NOT be accepted in the same cycle that a result is released.
REQ-017 On the accepting edge, the block SHALL:
- latch in_a, in_b and in_sub;
- clear the byte index to 0;
- clear out_sum.
Input changes after that edge SHALL be ignored.
REQ-018 The slice inputs for byte k SHALL be:
- operand A: a[8k+7:8k];
- operand B: b[8k+7:8k] XOR {8{sub}};
- carry-in: sub for k=0, otherwise the carry-out registered from byte k-1.
REQ-019 Each CALC edge SHALL write slice byte k into out_sum[8k+7:8k] and increment k.
REQ-020 After the edge that processes byte XLEN/8-1, the state SHALL be DONE and out_valid SHALL be 1; this is XLEN/8 edges after the accepting edge (4 for the default).
REQ-021 In DONE, out_sum and the flags SHALL hold stable while out_ready is 0, with no timeout.
REQ-022 The flags SHALL be:
- out_n = out_sum[XLEN-1].
- out_z = (out_sum == 0).
- out_c = carry out of bit XLEN-1; for subtract, 1 means no borrow.
- out_v = carry into bit XLEN-1 XOR carry out of bit XLEN-1.
REQ-023 Wrap-around SHALL be modulo 2^XLEN, with the carry reported only through out_c.
REQ-024 in_valid SHALL be ignored while the state is CALC or DONE.

Reset
REQ-025 While rst_n is 0, the block SHALL force:
- state = IDLE and byte index = 0;
- out_sum = 0;
- all flags = 0 and out_valid = 0;
- busy = 0 and in_ready = 0.
REQ-026 An assertion of rst_n in the middle of an operation SHALL abort it, discarding the operands and partial sum; no out_valid SHALL follow.
REQ-027 On the first rising edge after rst_n deasserts, in_ready SHALL be 1.

Configuration
REQ-028 The macro ADD_SEQ_CTRL_FLAGS_EN SHALL control flag generation.
- Defined: out_n, out_z, out_c and out_v SHALL behave per REQ-022.
- Undefined: the flag logic and the carry-into-MSB register SHALL be absent, and the four flag ports SHALL remain present, tied to 0.
- Either way: out_sum and the latency SHALL be identical.

Verification
REQ-029 The bench SHALL cover these cases (XLEN=32, flags enabled, out_ready=1 unless stated):
- a=0x7FFFFFFF, b=0x00000001, sub=0 -> out_sum=0x80000000, N=1, Z=0, C=0, V=1; out_valid rises 4 edges after acceptance.
- a=0xFFFFFFFF, b=0x00000001, sub=0 -> out_sum=0x00000000, N=0, Z=1, C=1, V=0; carry ripples through all 4 bytes.
- a=0x00000000, b=0x00000001, sub=1 -> out_sum=0xFFFFFFFF, N=1, Z=0, C=0, V=0.
- a=0x80000000, b=0x00000001, sub=1 -> out_sum=0x7FFFFFFF, N=0, Z=0, C=1, V=1.
- out_ready held at 0 for 10 cycles in DONE, with in_valid=1 and new operands applied -> result and flags unchanged, in_ready=0; on the out_ready pulse, return to IDLE, then the new request is accepted.
- rst_n pulsed low while the byte index is 2 -> outputs zero immediately, no out_valid follows, and in_ready=1 after release.
